alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/register width (>=4).
REQ-002 SHALL have parameter NUM_REGS, default 16, register file depth (power of 2, >=4); REG_AW = log2(NUM_REGS).
REQ-003 SHALL have parameter IP_W, default 16, branch target width (<= DATA_W).
REQ-004 SHALL have parameter LED_W, default 8, LED output width (<= DATA_W).
REQ-005 Clock  input  1  Clock; all state changes on its rising edge.
REQ-006 Reset  input  1  Clock domain uses one clock; reset is asynchronous and active-low.
REQ-007 iValid  input  1  instruction present.
REQ-008 oReady  output  1  unit can accept; transfer when iValid && oReady at a rising edge.
REQ-009 iOp  input  4  opcode.
REQ-010 iDst, iSrc1, iSrc0  input  REG_AW each  register addresses.
REQ-011 iImm  input  DATA_W  immediate / branch target.
REQ-012 oBranchTaken  output  1  one-cycle branch pulse.
REQ-013 oBranchTarget  output  IP_W  target held with the pulse.
REQ-014 oLed  output  LED_W  LED register.
REQ-015 oIllegal  output  1  one-cycle pulse for an undefined opcode.
REQ-016 iDbgAddr  input  REG_AW; oDbgData  output  DATA_W  combinational register read.

Function
REQ-017 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 SMUL, 4 STO, 5 BLE, 6 JMP, 7 LED, 8 SHL, 9 SHR (arithmetic), 10 AND, 11 OR; 12-15 undefined.
REQ-018 Register r0 SHALL read zero at all times; writes to r0 SHALL be discarded.
REQ-019 Sources SHALL be read from current register contents at the acceptance edge; results written at that same edge, so the next accepted instruction sees them (no hazard stalls).
REQ-020 ADD/SUB/AND/OR: r[dst] = r[src1] op r[src0], modulo 2^DATA_W, no flags.
REQ-021 STO: r[dst] = iImm.
REQ-022 SHL/SHR: amount = r[src0] unsigned; amount >= DATA_W SHALL yield 0 (SHL) or sign fill of r[src1] (SHR).
REQ-023 BLE: if signed r[src1] <= signed r[src0], oBranchTaken=1 for the cycle after acceptance, oBranchTarget = iImm[IP_W-1:0]; else no pulse.
REQ-024 JMP: unconditional pulse as REQ-023.
REQ-025 LED: oLed <= r[src1][LED_W-1:0] at acceptance edge.
REQ-026 Undefined opcode: no state change; oIllegal=1 for the cycle after acceptance.
REQ-027 SMUL: iterative signed multiply, FSM states IDLE -> MUL -> IDLE; on acceptance operands latched, oReady=0 for exactly DATA_W cycles; at the DATA_W-th edge after acceptance r[dst] = product[DATA_W-1:0], r[(dst+1) mod NUM_REGS] = product[2*DATA_W-1:DATA_W]; oReady=1 following that edge.
REQ-028 SMUL with dst = NUM_REGS-1 SHALL wrap the high half into r0 (i.e. discarded); dst = 0 SHALL discard low half and write high half to r1.
REQ-029 SMUL product SHALL be exact for all signed operand pairs, including most-negative x most-negative.
REQ-030 oReady SHALL be 1 in IDLE; iValid while oReady=0 SHALL be ignored (no acceptance).
REQ-031 NOP accepted SHALL change nothing.

Reset
REQ-032 Reset low SHALL immediately clear all registers to 0, oLed=0, oBranchTaken=0, oBranchTarget=0, oIllegal=0, FSM=IDLE, oReady=1.
REQ-033 Reset asserted during SMUL SHALL abort it with no register write; first instruction after release is accepted normally.

Verification
REQ-034 STO r1=5, STO r2=-3, ADD r3=r1+r2 back-to-back -> oDbgData(r3)=2 immediately after third acceptance.
REQ-035 DATA_W=16: STO r1=0x8000, r2=0x8000, SMUL dst=4 -> oReady low 16 cycles, then r4=0x0000, r5=0x4000.
REQ-036 STO r1=7, r2=7, BLE imm=0x0123 -> oBranchTaken=1 one cycle, target 0x0123; r1=8 -> no pulse.
REQ-037 SHR r1=0x8000 by r2=20 -> 0xFFFF; SHL same -> 0x0000; STO to r0 -> r0 reads 0.
REQ-038 SMUL dst=15 (NUM_REGS=16), Reset low at cycle 8 -> r15 unchanged (0), oReady=1 during reset; opcode 13 -> oIllegal pulse, no register change.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - register-file ALU execute unit with iterative signed multiply
//
// Accepts one instruction per cycle (iValid && oReady). Sources are read from
// the register file at the acceptance edge and results are written at that same
// edge. SMUL is the only multi-cycle operation: it runs a shift-add multiply
// over DATA_W cycles with oReady low, then writes the low half to r[dst] and
// the high half to r[dst+1] (both wrap mod NUM_REGS; r0 always reads zero).
//
// Ports:
//   Clock, Reset          clock, asynchronous active-low reset
//   iValid / oReady       instruction handshake
//   iOp, iDst, iSrc1,
//   iSrc0, iImm           instruction fields
//   oBranchTaken          one-cycle pulse after an accepted taken BLE / JMP
//   oBranchTarget         target of the most recent taken branch
//   oLed                  LED register
//   oIllegal              one-cycle pulse after an accepted undefined opcode
//   iDbgAddr / oDbgData   combinational register read port

module alu_exec_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IP_W     = 16,
  parameter int LED_W    = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [3:0]        iOp,
  input  logic [REG_AW-1:0] iDst,
  input  logic [REG_AW-1:0] iSrc1,
  input  logic [REG_AW-1:0] iSrc0,
  input  logic [DATA_W-1:0] iImm,
  output logic              oBranchTaken,
  output logic [IP_W-1:0]   oBranchTarget,
  output logic [LED_W-1:0]  oLed,
  output logic              oIllegal,
  input  logic [REG_AW-1:0] iDbgAddr,
  output logic [DATA_W-1:0] oDbgData
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DATA_W-1:0] SHAMT_LIM = DATA_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SMUL = 4'd3;
  localparam logic [3:0] OP_STO  = 4'd4;
  localparam logic [3:0] OP_BLE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_LED  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_OR   = 4'd11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  logic [LED_W-1:0]      led_q, led_d;
  logic                  br_q, br_d;
  logic [IP_W-1:0]       tgt_q, tgt_d;
  logic                  ill_q, ill_d;

  // Multiplier datapath: multiplicand is sign-extended to 2*DATA_W and shifted
  // left each step; multiplier bits are consumed LSB first.
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_AW-1:0]     mdst_q, mdst_d;

  logic                  accept;
  logic [DATA_W-1:0]     src1_val;
  logic [DATA_W-1:0]     src0_val;
  logic [2*DATA_W-1:0]   mul_sum;
  logic                  mul_last;

  assign oReady        = (state_q == ST_IDLE);
  assign accept        = iValid && oReady;
  assign src1_val      = regs_q[iSrc1];
  assign src0_val      = regs_q[iSrc0];
  assign oBranchTaken  = br_q;
  assign oBranchTarget = tgt_q;
  assign oLed          = led_q;
  assign oIllegal      = ill_q;
  assign oDbgData      = regs_q[iDbgAddr];

  assign mul_last = (cnt_q == CNT_LAST);

  // The multiplier MSB carries weight -2^(DATA_W-1) in two's complement, so the
  // final partial product is subtracted instead of added. This keeps the result
  // exact for every signed pair, including most-negative squared.
  always_comb begin
    mul_sum = acc_q;
    if (mplier_q[0]) begin
      if (mul_last) begin
        mul_sum = acc_q - mcand_q;
      end else begin
        mul_sum = acc_q + mcand_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    led_d    = led_q;
    br_d     = 1'b0;
    tgt_d    = tgt_q;
    ill_d    = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mdst_d   = mdst_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (iOp)
            OP_NOP: ;
            OP_ADD: regs_d[iDst] = src1_val + src0_val;
            OP_SUB: regs_d[iDst] = src1_val - src0_val;
            OP_SMUL: begin
              acc_d    = '0;
              mcand_d  = {{DATA_W{src1_val[DATA_W-1]}}, src1_val};
              mplier_d = src0_val;
              cnt_d    = '0;
              mdst_d   = iDst;
              state_d  = ST_MUL;
            end
            OP_STO: regs_d[iDst] = iImm;
            OP_BLE: begin
              if ($signed(src1_val) <= $signed(src0_val)) begin
                br_d  = 1'b1;
                tgt_d = iImm[IP_W-1:0];
              end
            end
            OP_JMP: begin
              br_d  = 1'b1;
              tgt_d = iImm[IP_W-1:0];
            end
            OP_LED: led_d = src1_val[LED_W-1:0];
            OP_SHL: begin
              if (src0_val >= SHAMT_LIM) begin
                regs_d[iDst] = '0;
              end else begin
                regs_d[iDst] = src1_val << src0_val;
              end
            end
            OP_SHR: begin
              if (src0_val >= SHAMT_LIM) begin
                regs_d[iDst] = {DATA_W{src1_val[DATA_W-1]}};
              end else begin
                regs_d[iDst] = $signed(src1_val) >>> src0_val;
              end
            end
            OP_AND: regs_d[iDst] = src1_val & src0_val;
            OP_OR:  regs_d[iDst] = src1_val | src0_val;
            default: ill_d = 1'b1;
          endcase
        end
      end

      ST_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_last) begin
          regs_d[mdst_d]        = mul_sum[DATA_W-1:0];
          regs_d[mdst_q + 1'b1] = mul_sum[2*DATA_W-1:DATA_W];
          state_d               = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // r0 is hardwired to zero regardless of which path targeted it.
    regs_d[0] = '0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      regs_q   <= '{default: '0};
      led_q    <= '0;
      br_q     <= 1'b0;
      tgt_q    <= '0;
      ill_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mdst_q   <= '0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      led_q    <= led_d;
      br_q     <= br_d;
      tgt_q    <= tgt_d;
      ill_q    <= ill_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      mdst_q   <= mdst_d;
    end
  end

endmodule
